// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions. Holds the memory-op encoding, the
//               memory-stage FSM state type, the default bus timeout, the
//               legacy pipeline constants, and helpers that compute byte
//               enables, store-lane replication and alignment.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Legacy pipeline constants
  localparam logic [4:0]  NOPRegAddr = 5'b00000;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Default number of cycles to wait for a bus acknowledge
  localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(mem_op_t op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Little-endian lane enables. Halfword/word ignore the low address bits
  // they do not need, so misaligned accesses fall onto the aligned lanes.
  function automatic logic [3:0] calc_be(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << a;
      MEM_LH, MEM_LHU, MEM_SH: return a[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:          return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

  // Store data is replicated across every lane; the slave picks lanes by be.
  function automatic logic [31:0] calc_wdata(mem_op_t op, logic [31:0] d);
    case (op)
      MEM_SB:  return {4{d[7:0]}};
      MEM_SH:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return (a != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load-data aligner. Selects the addressed byte
//               or halfword from a 32-bit bus word and sign/zero-extends it.
// Ports       : addr_i  [1:0]  low address bits of the load
//               op_i    [3:0]  mem_op_t of the load
//               rdata_i [31:0] raw bus read word
//               data_o  [31:0] extended result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import cpu_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (addr_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (mem_op_t'(op_i))
      MEM_LB:  data_o = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: data_o = {24'h000000, w_byte};
      MEM_LH:  data_o = {{16{w_half[15]}}, w_half};
      MEM_LHU: data_o = {16'h0000, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Non-memory instructions pass straight
//               through. Loads/stores stall the pipe, issue one bus request
//               (IDLE -> BUSY -> DONE) and deliver the load result or the
//               store completion in DONE. A bus that never acknowledges
//               raises a one-cycle bus error after BUS_TIMEOUT cycles.
// Config      : MEM_ADDR_EXC_EN - when defined, misaligned halfword/word
//               accesses raise exc_adel_o/exc_ades_o in IDLE instead of
//               issuing; when undefined they are forced aligned.
// Ports       : clk, rst              clock, synchronous active-high reset
//               valid_i, flush_i      live instruction, kill request
//               wd/wreg/wdata/whilo/hi/lo/cp0_* _i -> _o   MEM/WB payload
//               mem_op_i, mem_addr_i, mem_sdata_i          memory operation
//               stall_o               freeze IF..EX/MEM
//               bus_* _o / bus_ack_i, bus_rdata_i          data bus
//               exc_adel_o, exc_ades_o, exc_buserr_o, badvaddr_o
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import cpu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        cp0_reg_we_i,
  input  logic [4:0]  cp0_reg_write_addr_i,
  input  logic [31:0] cp0_reg_data_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        cp0_reg_we_o,
  output logic [4:0]  cp0_reg_write_addr_o,
  output logic [31:0] cp0_reg_data_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        exc_buserr_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [15:0] c_TO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        flush_q, flush_d;
  logic        buserr_q, buserr_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  mem_op_t     w_op;
  logic        w_is_mem;
  logic        w_adel, w_ades, w_exc;
  logic        w_start;
  logic [31:0] w_align;
  logic        w_en;
  logic        w_ld_wr;

  assign w_op     = mem_op_t'(mem_op_i);
  assign w_is_mem = is_load(w_op) || is_store(w_op);

`ifdef MEM_ADDR_EXC_EN
  assign w_adel = (state_q == ST_IDLE) && valid_i && is_load(w_op)
                  && misaligned(w_op, mem_addr_i[1:0]);
  assign w_ades = (state_q == ST_IDLE) && valid_i && is_store(w_op)
                  && misaligned(w_op, mem_addr_i[1:0]);
`else
  assign w_adel = 1'b0;
  assign w_ades = 1'b0;
`endif
  assign w_exc   = w_adel || w_ades;
  assign w_start = (state_q == ST_IDLE) && valid_i && w_is_mem && !w_exc && !flush_i;

  mem_load_align u_align (
    .addr_i  (addr_q[1:0]),
    .op_i    (op_q),
    .rdata_i (bus_rdata_i),
    .data_o  (w_align)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    flush_d  = flush_q;
    buserr_d = buserr_q;
    op_d     = op_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          state_d  = ST_BUSY;
          cnt_d    = 16'd0;
          op_d     = w_op;
          addr_d   = mem_addr_i;
          we_d     = is_store(w_op);
          be_d     = calc_be(w_op, mem_addr_i[1:0]);
          wdata_d  = calc_wdata(w_op, mem_sdata_i);
          flush_d  = 1'b0;
          buserr_d = 1'b0;
        end
      end
      ST_BUSY: begin
        // A flush cannot abort an outstanding bus cycle; remember it and
        // discard the result once the bus completes.
        if (flush_i) flush_d = 1'b1;
        if (bus_ack_i) begin
          rdata_d = w_align;
          state_d = ST_DONE;
        end else if (cnt_q == c_TO_LAST) begin
          buserr_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        flush_d  = 1'b0;
        buserr_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      rdata_q  <= ZeroWord;
      flush_q  <= 1'b0;
      buserr_q <= 1'b0;
      op_q     <= MEM_NONE;
      addr_q   <= ZeroWord;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= ZeroWord;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      flush_q  <= flush_d;
      buserr_q <= buserr_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  // Output logic; everything is forced to zero while reset is held.
  always_comb begin
    w_en                 = 1'b0;
    w_ld_wr              = 1'b1;
    wd_o                 = NOPRegAddr;
    wreg_o               = 1'b0;
    wdata_o              = ZeroWord;
    whilo_o              = 1'b0;
    hi_o                 = ZeroWord;
    lo_o                 = ZeroWord;
    cp0_reg_we_o         = 1'b0;
    cp0_reg_write_addr_o = 5'd0;
    cp0_reg_data_o       = ZeroWord;
    stall_o              = 1'b0;
    bus_req_o            = 1'b0;
    bus_we_o             = 1'b0;
    bus_be_o             = 4'b0000;
    bus_addr_o           = ZeroWord;
    bus_wdata_o          = ZeroWord;
    exc_adel_o           = 1'b0;
    exc_ades_o           = 1'b0;
    exc_buserr_o         = 1'b0;
    badvaddr_o           = ZeroWord;
    if (!rst) begin
      wd_o                 = wd_i;
      wdata_o              = wdata_i;
      hi_o                 = hi_i;
      lo_o                 = lo_i;
      cp0_reg_write_addr_o = cp0_reg_write_addr_i;
      cp0_reg_data_o       = cp0_reg_data_i;
      case (state_q)
        ST_IDLE: begin
          // A live memory op in IDLE either issues (stalls) or faults;
          // neither may write back this cycle.
          w_en       = !flush_i && !(valid_i && w_is_mem);
          stall_o    = w_start;
          exc_adel_o = w_adel;
          exc_ades_o = w_ades;
          if (w_exc) badvaddr_o = mem_addr_i;
        end
        ST_BUSY: begin
          stall_o     = 1'b1;
          bus_req_o   = 1'b1;
          bus_we_o    = we_q;
          bus_be_o    = be_q;
          bus_addr_o  = {addr_q[31:2], 2'b00};
          bus_wdata_o = wdata_q;
        end
        ST_DONE: begin
          w_en         = !flush_q && !buserr_q && !flush_i;
          w_ld_wr      = !we_q;
          wdata_o      = we_q ? wdata_i : rdata_q;
          exc_buserr_o = buserr_q && !flush_q && !flush_i;
          if (buserr_q && !flush_q && !flush_i) badvaddr_o = addr_q;
        end
        default: w_en = 1'b0;
      endcase
      wreg_o       = w_en && w_ld_wr && wreg_i;
      whilo_o      = w_en && whilo_i;
      cp0_reg_we_o = w_en && cp0_reg_we_i;
    end
  end

endmodule : mem_access
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255: max cycles waiting for bus_ack_i before bus error; legal range 1..65535.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  EX/MEM register holds a live instruction.
REQ-005 wd_i, wreg_i, wdata_i  input  5,1,32  GPR write address, enable, ALU result.
REQ-006 whilo_i, hi_i, lo_i  input  1,32,32  HI/LO write enable and data.
REQ-007 cp0_reg_we_i, cp0_reg_write_addr_i, cp0_reg_data_i  input  1,5,32  CP0 write request.
REQ-008 mem_op_i  input  4  mem_op_t: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-009 mem_addr_i, mem_sdata_i  input  32,32  effective address, store source register.
REQ-010 flush_i  input  1  kill current instruction (exception/redirect from later stage).
REQ-011 wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, cp0_reg_we_o, cp0_reg_write_addr_o, cp0_reg_data_o  output  as inputs  to MEM/WB.
REQ-012 stall_o  output  1  freeze IF..EX/MEM this cycle.
REQ-013 bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o  output  1,1,4,32,32  data bus request.
REQ-014 bus_ack_i, bus_rdata_i  input  1,32  one-cycle ack, read data valid with ack.
REQ-015 exc_adel_o, exc_ades_o, exc_buserr_o, badvaddr_o  output  1,1,1,32  exception flags, faulting address.

Function
REQ-016 FSM states IDLE, BUSY, DONE; mem_op NONE or valid_i=0 stays IDLE and passes all inputs to outputs combinationally, stall_o=0.
REQ-017 IDLE, valid_i=1, mem op, no exception, flush_i=0 -> BUSY next edge; stall_o=1 in that cycle.
REQ-018 BUSY: bus_req_o=1, address/we/be/wdata registered on IDLE->BUSY edge and held constant until ack; stall_o=1.
REQ-019 bus_addr_o = {mem_addr_i[31:2],2'b00}; be: SB one-hot on addr[1:0] (little-endian), SH 4'b0011/4'b1100 by addr[1], SW 4'b1111; loads same be.
REQ-020 bus_wdata_o replicates byte/halfword of mem_sdata_i across all lanes.
REQ-021 BUSY with bus_ack_i=1 -> DONE; load data extracted by latched addr[1:0], sign-extended (LB, LH) or zero-extended (LBU, LHU), stored in rdata register.
REQ-022 DONE: stall_o=0, wdata_o = rdata register for loads, wdata_i for stores; wreg_o=0 for stores; next edge -> IDLE. Minimum memory-op latency: 3 cycles incl. issue cycle with zero-wait ack.
REQ-023 Cycle counter cleared on BUSY entry; reaching BUSY_TIMEOUT without ack -> exc_buserr_o=1 for one cycle in DONE, all write enables 0, bus_req_o dropped.
REQ-024 flush_i in IDLE: all write enables 0, no bus request. flush_i in BUSY: request NOT aborted; completion discarded (enables 0 in DONE); flag held in a register.
REQ-025 Ack arriving in IDLE or DONE ignored.
REQ-026 When stall_o=1 all write enables to MEM/WB are 0.

Reset
REQ-027 rst=1 at edge: FSM IDLE, counter 0, rdata 0, flush flag 0, bus regs 0.
REQ-028 While rst=1: every output 0 (wd_o = NOPRegAddr), independent of inputs; rst mid-BUSY drops bus_req_o next edge.

Configuration
REQ-029 Macro MEM_ADDR_EXC_EN: defined -> misaligned LH/LHU/LW assert exc_adel_o, SH/SW exc_ades_o, badvaddr_o=mem_addr_i, combinational in IDLE, no bus request, enables 0; undefined -> exc_adel_o/exc_ades_o tied 0, addr low bits ignored for halfword/word (forced aligned).

Structure
REQ-030 mem_op_t enum, state enum and BUS_TIMEOUT default live in shared package cpu_pkg alongside define.vh constants.
REQ-031 Sub-module mem_load_align (combinational: addr[1:0], op, rdata -> extended 32-bit word) instantiated once.

Verification
REQ-032 LW addr 0x100, ack after 2 wait cycles rdata 0xDEADBEEF -> stall 4 cycles, wdata_o 0xDEADBEEF, wreg_o 1 in DONE.
REQ-033 LB addr 0x103, rdata 0x80FF_FFFF -> wdata_o 0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH addr 0x202 data 0x1234ABCD -> be 4'b1100, wdata 0xABCDABCD, wreg_o 0.
REQ-035 LW with no ack, BUS_TIMEOUT=4 -> bus_req_o high exactly 4 cycles, exc_buserr_o pulse, no register write.
REQ-036 flush_i in 2nd BUSY cycle, ack 1 cycle later -> request held until ack, DONE enables all 0.
REQ-037 MEM_ADDR_EXC_EN defined, LW addr 0x101 -> exc_adel_o 1, badvaddr_o 0x101, bus_req_o never asserted; rst during BUSY -> all outputs 0 next cycle.
